// File: rtl/mct_word.sv
// Word-to-byte memory access engine; optional write path under `MCT_WRITE_EN.
// Latency: read response WORD_BYTES+2 cycles after accept, write WORD_BYTES+1; req_ready only in IDLE.
// Backpressure: one request in flight, req_valid ignored while busy; accept allowed in the resp_valid cycle.
module mct_word #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [8*WORD_BYTES-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [8*WORD_BYTES-1:0] resp_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_wr,
    output logic [7:0]              mem_dout,
    input  logic [7:0]              mem_din,
    output logic                    busy
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int CW = $clog2(WORD_BYTES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD      = 2'd1;
    localparam logic [1:0] S_RD_LAST = 2'd2;
`ifdef MCT_WRITE_EN
    localparam logic [1:0] S_WR      = 2'd3;
`endif

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [W-1:0]      rbuf_q, rbuf_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              resp_valid_q, resp_valid_d;
    logic [W-1:0]      resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [W-1:0]      rd_shift;
    logic [ADDR_W-1:0] next_addr;
    logic              last_byte;

`ifdef MCT_WRITE_EN
    logic [W-1:0]      wdata_q, wdata_d;
    logic              mem_wr_q, mem_wr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;

    // Byte i of the word in transfer order; first byte is the MSB when big-endian.
    function automatic logic [7:0] pick(input logic [W-1:0] w, input logic [CW-1:0] i);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (i == CW'(k)) begin
                r = w[((BIG_ENDIAN != 0) ? (WORD_BYTES - 1 - k) : k) * 8 +: 8];
            end
        end
        return r;
    endfunction
`else
    logic unused_wr;
    assign unused_wr = ^{req_wr, req_wdata};
`endif

    always_comb begin
        if (BIG_ENDIAN != 0) begin
            rd_shift = (rbuf_q << 8) | W'(mem_din);
        end else begin
            rd_shift = (rbuf_q >> 8) | (W'(mem_din) << (W - 8));
        end
    end

    assign next_addr = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
    assign last_byte = (cnt_q == CW'(WORD_BYTES - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        rbuf_d       = rbuf_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
`ifdef MCT_WRITE_EN
        wdata_d      = wdata_q;
        mem_wr_d     = mem_wr_q;
        mem_dout_d   = mem_dout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    cnt_d       = '0;
                    mem_addr_d  = req_addr;
                    req_ready_d = 1'b0;
                    state_d     = S_RD;
`ifdef MCT_WRITE_EN
                    if (req_wr) begin
                        wdata_d    = req_wdata;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = pick(req_wdata, '0);
                        state_d    = S_WR;
                    end
`endif
                end
            end
            S_RD: begin
                // mem_din lags its address by one cycle, so byte cnt-1 lands now.
                if (cnt_q != '0) begin
                    rbuf_d = rd_shift;
                end
                if (last_byte) begin
                    mem_addr_d = '0;
                    state_d    = S_RD_LAST;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    mem_addr_d = next_addr;
                end
            end
            S_RD_LAST: begin
                resp_rdata_d = rd_shift;
                resp_valid_d = 1'b1;
                req_ready_d  = 1'b1;
                cnt_d        = '0;
                state_d      = S_IDLE;
            end
`ifdef MCT_WRITE_EN
            S_WR: begin
                if (last_byte) begin
                    mem_wr_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_dout_d   = '0;
                    resp_valid_d = 1'b1;
                    req_ready_d  = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    mem_addr_d = next_addr;
                    mem_dout_d = pick(wdata_q, cnt_q + CW'(1));
                end
            end
`endif
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
        busy_d = ~req_ready_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            rbuf_q       <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            rbuf_q       <= rbuf_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

`ifdef MCT_WRITE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdata_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= '0;
        end else begin
            wdata_q    <= wdata_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
        end
    end

    assign mem_wr   = mem_wr_q;
    assign mem_dout = mem_dout_q;
`else
    assign mem_wr   = 1'b0;
    assign mem_dout = '0;
`endif

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_mct_word.sv
// Bench for mct_word: big- and little-endian instances share one request stream.
module tb_mct_word;

`ifdef MCT_WRITE_EN
    localparam int WR_EN = 1;
`else
    localparam int WR_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr;
    logic [31:0] req_addr, req_wdata;

    logic        be_req_ready, be_resp_valid, be_mem_wr, be_busy;
    logic [31:0] be_resp_rdata, be_mem_addr;
    logic [7:0]  be_mem_dout, be_mem_din;
    logic        le_req_ready, le_resp_valid, le_mem_wr, le_busy;
    logic [31:0] le_resp_rdata, le_mem_addr;
    logic [7:0]  le_mem_dout, le_mem_din;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] q_be[$], q_le[$];
    logic [39:0] wl_be[$], wl_le[$];
    logic [31:0] last_be, last_le, exp_be, exp_le;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mct_word #(.ADDR_W(32), .WORD_BYTES(4), .BIG_ENDIAN(1)) u_be (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(be_req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(be_resp_valid), .resp_rdata(be_resp_rdata),
        .mem_addr(be_mem_addr), .mem_wr(be_mem_wr), .mem_dout(be_mem_dout),
        .mem_din(be_mem_din), .busy(be_busy));

    mct_word #(.ADDR_W(32), .WORD_BYTES(4), .BIG_ENDIAN(0)) u_le (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(le_req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(le_resp_valid), .resp_rdata(le_resp_rdata),
        .mem_addr(le_mem_addr), .mem_wr(le_mem_wr), .mem_dout(le_mem_dout),
        .mem_din(le_mem_din), .busy(le_busy));

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            default: return a[7:0] ^ a[15:8] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a, input bit big);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem_byte(a);
        b1 = mem_byte(a + 32'd1);
        b2 = mem_byte(a + 32'd2);
        b3 = mem_byte(a + 32'd3);
        return big ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    endfunction

    // Byte memory: data appears the cycle after its address.
    always @(posedge clk) begin
        be_mem_din <= mem_byte(be_mem_addr);
        le_mem_din <= mem_byte(le_mem_addr);
    end

    always @(negedge clk) begin
        if (rst) begin
            if (be_resp_valid) begin
                checks++;
                if (q_be.size() == 0) begin
                    errors++;
                    $display("FAIL sb_be unexpected resp_valid rdata=%h", be_resp_rdata);
                end else begin
                    exp_be = q_be.pop_front();
                    if (be_resp_rdata !== exp_be) begin
                        errors++;
                        $display("FAIL sb_be rdata got=%h exp=%h", be_resp_rdata, exp_be);
                    end
                end
            end
            if (le_resp_valid) begin
                checks++;
                if (q_le.size() == 0) begin
                    errors++;
                    $display("FAIL sb_le unexpected resp_valid rdata=%h", le_resp_rdata);
                end else begin
                    exp_le = q_le.pop_front();
                    if (le_resp_rdata !== exp_le) begin
                        errors++;
                        $display("FAIL sb_le rdata got=%h exp=%h", le_resp_rdata, exp_le);
                    end
                end
            end
            if (be_mem_wr) wl_be.push_back({be_mem_addr, be_mem_dout});
            if (le_mem_wr) wl_le.push_back({le_mem_addr, le_mem_dout});
        end
    end

    task automatic push_exp(input logic wr, input logic [31:0] addr);
        if (wr && WR_EN != 0) begin
            q_be.push_back(last_be);
            q_le.push_back(last_le);
        end else begin
            last_be = exp_word(addr, 1'b1);
            last_le = exp_word(addr, 1'b0);
            q_be.push_back(last_be);
            q_le.push_back(last_le);
        end
    endtask

    // Presents one request; returns 1 time unit after the accepting edge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        while (!be_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL send_timeout req_ready stuck low got=%b exp=1", be_req_ready);
        end
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        push_exp(wr, addr);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((be_busy || be_resp_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL idle_timeout busy got=%b exp=0", be_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        last_be = '0; last_le = '0;
        #12;
        checks += 8;
        if (be_req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", be_req_ready); end
        if (be_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", be_busy); end
        if (be_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got=%b exp=0", be_resp_valid); end
        if (be_resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", be_resp_rdata); end
        if (be_mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", be_mem_addr); end
        if (be_mem_wr !== 1'b0) begin errors++; $display("FAIL rst_wr got=%b exp=0", be_mem_wr); end
        if (be_mem_dout !== 8'h0) begin errors++; $display("FAIL rst_dout got=%h exp=0", be_mem_dout); end
        if (le_resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_le_rdata got=%h exp=0", le_resp_rdata); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        logic [31:0] ea;
        send(1'b0, 32'h100, '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ea = (k < 4) ? 32'h100 + k : 32'h0;
            checks += 4;
            if (be_mem_addr !== ea) begin errors++; $display("FAIL rd_addr k=%0d got=%h exp=%h", k, be_mem_addr, ea); end
            if (le_mem_addr !== ea) begin errors++; $display("FAIL rd_le_addr k=%0d got=%h exp=%h", k, le_mem_addr, ea); end
            if (be_resp_valid !== (k == 5)) begin errors++; $display("FAIL rd_rv k=%0d got=%b exp=%b", k, be_resp_valid, k == 5); end
            if (be_busy !== (k < 5)) begin errors++; $display("FAIL rd_busy k=%0d got=%b exp=%b", k, be_busy, k < 5); end
        end
        @(negedge clk);
        checks += 3;
        if (be_resp_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse got=%b exp=0", be_resp_valid); end
        if (be_resp_rdata !== 32'h11223344) begin errors++; $display("FAIL rd_be_word got=%h exp=11223344", be_resp_rdata); end
        if (le_resp_rdata !== 32'h44332211) begin errors++; $display("FAIL rd_le_word got=%h exp=44332211", le_resp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [31:0] tab [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        send(1'b0, 32'hFFFF_FFFE, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (be_mem_addr !== tab[k]) begin errors++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, be_mem_addr, tab[k]); end
        end
        wait_idle();
    endtask

    task automatic test_write();
        logic [39:0] eb [4] = '{{32'h20, 8'hDE}, {32'h21, 8'hAD}, {32'h22, 8'hBE}, {32'h23, 8'hEF}};
        logic [39:0] el [4] = '{{32'h20, 8'hEF}, {32'h21, 8'hBE}, {32'h22, 8'hAD}, {32'h23, 8'hDE}};
        logic [39:0] got;
        int          rv_k;
        wl_be.delete(); wl_le.delete();
        rv_k = (WR_EN != 0) ? 4 : 5;
        send(1'b1, 32'h20, 32'hDEAD_BEEF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks += 2;
            if (be_resp_valid !== (k == rv_k)) begin errors++; $display("FAIL wr_rv k=%0d got=%b exp=%b", k, be_resp_valid, k == rv_k); end
            if (be_mem_wr !== (WR_EN != 0 && k < 4)) begin errors++; $display("FAIL wr_strobe k=%0d got=%b exp=%b", k, be_mem_wr, WR_EN != 0 && k < 4); end
        end
        checks += 2;
        if (wl_be.size() != 4 * WR_EN) begin errors++; $display("FAIL wr_count_be got=%0d exp=%0d", wl_be.size(), 4 * WR_EN); end
        if (wl_le.size() != 4 * WR_EN) begin errors++; $display("FAIL wr_count_le got=%0d exp=%0d", wl_le.size(), 4 * WR_EN); end
        for (int k = 0; k < 4; k++) begin
            if (wl_be.size() > 0) begin
                got = wl_be.pop_front();
                checks++;
                if (got !== eb[k]) begin errors++; $display("FAIL wr_be_byte k=%0d got=%h exp=%h", k, got, eb[k]); end
            end
            if (wl_le.size() > 0) begin
                got = wl_le.pop_front();
                checks++;
                if (got !== el[k]) begin errors++; $display("FAIL wr_le_byte k=%0d got=%h exp=%h", k, got, el[k]); end
            end
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'h100, 32'h200, 32'hFFFF_FFFD};
        int          ecyc [3];
        int          acc, n;
        acc = 0; n = 0;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = addrs[0];
        while (acc < 3 && n < 40) begin
            if (be_req_ready) begin
                push_exp(1'b0, addrs[acc]);
                @(posedge clk); #1;
                ecyc[acc] = cyc;
                acc++;
                if (acc < 3) req_addr = addrs[acc];
                else req_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        req_valid = 1'b0;
        checks++;
        if (acc != 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", acc); end
        for (int k = 1; k < acc; k++) begin
            checks++;
            if (ecyc[k] - ecyc[k-1] != 6) begin errors++; $display("FAIL b2b_gap k=%0d got=%0d exp=6", k, ecyc[k] - ecyc[k-1]); end
        end
        wait_idle();
        checks++;
        if (q_be.size() != 0 || q_le.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending got=%0d exp=0", q_be.size() + q_le.size());
        end
    endtask

    task automatic test_reset_abort();
        send(1'b0, 32'h300, '0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        checks++;
        if (be_mem_addr !== 32'h302) begin errors++; $display("FAIL abort_pre got=%h exp=302", be_mem_addr); end
        rst = 1'b0;
        q_be.delete(); q_le.delete();
        last_be = '0; last_le = '0;
        #1;
        checks += 6;
        if (be_mem_addr !== 32'h0) begin errors++; $display("FAIL abort_addr got=%h exp=0", be_mem_addr); end
        if (be_req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", be_req_ready); end
        if (be_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", be_busy); end
        if (be_resp_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata got=%h exp=0", be_resp_rdata); end
        if (le_resp_rdata !== 32'h0) begin errors++; $display("FAIL abort_le_rdata got=%h exp=0", le_resp_rdata); end
        if (be_resp_valid !== 1'b0) begin errors++; $display("FAIL abort_rv got=%b exp=0", be_resp_valid); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (be_resp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_resp k=%0d got=%b exp=0", k, be_resp_valid); end
        end
        @(posedge clk); #1;
        send(1'b0, 32'h100, '0);
        wait_idle();
        checks += 2;
        if (be_resp_rdata !== 32'h11223344) begin errors++; $display("FAIL abort_after_be got=%h exp=11223344", be_resp_rdata); end
        if (le_resp_rdata !== 32'h44332211) begin errors++; $display("FAIL abort_after_le got=%h exp=44332211", le_resp_rdata); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_wrap();
        test_write();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(negedge clk);
        checks++;
        if (q_be.size() != 0 || q_le.size() != 0) begin
            errors++;
            $display("FAIL final_pending got=%0d exp=0", q_be.size() + q_le.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
